// File: rtl/cnn_seq_pkg.sv
// Shared encodings for the CNN forward-pass sequencer: state codes, stage bit positions and widths.
package cnn_seq_pkg;
  localparam int NUM_STAGES = 5;
  localparam int LIDX_W     = 3;

  localparam int STG_W = 0;
  localparam int STG_I = 1;
  localparam int STG_S = 2;
  localparam int STG_R = 3;
  localparam int STG_P = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t CW   = 3'd1;
  localparam state_t CI   = 3'd2;
  localparam state_t CS   = 3'd3;
  localparam state_t CR   = 3'd4;
  localparam state_t CP   = 3'd5;
  localparam state_t FC   = 3'd6;
  localparam state_t FIN  = 3'd7;
endpackage

// File: rtl/cnn_seq_watchdog.sv
// Per-stage cycle counter; expired fires on the last cycle before LIMIT cycles of stalling have elapsed.
module cnn_seq_watchdog
  import cnn_seq_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Forward-pass sequencer: W->I->S->R->(P) per conv layer, then one FC engine at a time.
// Optional stage watchdog built when CNN_SEQ_TIMEOUT_EN is defined.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int NUM_CONV    = 2,
  parameter int NUM_FC      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_bit,
  input  logic                  abort,
  input  logic [NUM_CONV-1:0]   skip_pool,
  input  logic [NUM_STAGES-1:0] conv_done,
  input  logic [NUM_FC-1:0]     fc_done,
  output logic [NUM_STAGES-1:0] conv_load,
  output logic [LIDX_W-1:0]     layer_idx,
  output logic [NUM_FC-1:0]     fc_start,
  output logic                  busy,
  output logic                  done_fwd,
  output logic                  err_timeout
);
  localparam int FW = (NUM_FC > 1) ? $clog2(NUM_FC) : 1;
  localparam logic [LIDX_W-1:0] L_LAST = LIDX_W'(NUM_CONV - 1);
  localparam logic [FW-1:0]     F_LAST = FW'(NUM_FC - 1);

  state_t                state_q, state_d;
  logic [LIDX_W-1:0]     l_q, l_d;
  logic [FW-1:0]         f_q, f_d;
  logic [NUM_CONV-1:0]   skip_q, skip_d;
  logic                  start_q;
  logic                  start_edge;
  logic                  skip_cur;
  logic                  fc_done_cur;
  logic                  stage_done;
  logic                  adv_layer;
  logic                  wd_expired;
  logic [NUM_STAGES-1:0] conv_load_d;
  logic [NUM_FC-1:0]     fc_start_d;
  logic [LIDX_W-1:0]     layer_idx_d;
  logic                  busy_d, done_d, err_d;

  assign start_edge = start_bit & ~start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      f_q         <= '0;
      skip_q      <= '0;
      start_q     <= 1'b0;
      conv_load   <= '0;
      fc_start    <= '0;
      layer_idx   <= '0;
      busy        <= 1'b0;
      done_fwd    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      f_q         <= f_d;
      skip_q      <= skip_d;
      start_q     <= start_bit;
      conv_load   <= conv_load_d;
      fc_start    <= fc_start_d;
      layer_idx   <= layer_idx_d;
      busy        <= busy_d;
      done_fwd    <= done_d;
      err_timeout <= err_d;
    end
  end

  // Only the done bit belonging to the running stage can advance the sequence.
  always_comb begin
    skip_cur    = 1'b0;
    fc_done_cur = 1'b0;
    for (int k = 0; k < NUM_CONV; k++) begin
      if (l_q == LIDX_W'(k)) skip_cur = skip_q[k];
    end
    for (int k = 0; k < NUM_FC; k++) begin
      if (f_q == FW'(k)) fc_done_cur = fc_done[k];
    end
    case (state_q)
      CW:      stage_done = conv_done[STG_W];
      CI:      stage_done = conv_done[STG_I];
      CS:      stage_done = conv_done[STG_S];
      CR:      stage_done = conv_done[STG_R];
      CP:      stage_done = conv_done[STG_P];
      FC:      stage_done = fc_done_cur;
      default: stage_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    f_d       = f_q;
    skip_d    = skip_q;
    adv_layer = 1'b0;
    if (state_q == IDLE) begin
      if (start_edge) begin
        state_d = CW;
        l_d     = '0;
        f_d     = '0;
        skip_d  = skip_pool;
      end
    end else if (abort || wd_expired) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        CW: if (stage_done) state_d = CI;
        CI: if (stage_done) state_d = CS;
        CS: if (stage_done) state_d = CR;
        CR: begin
          if (stage_done) begin
            if (skip_cur) adv_layer = 1'b1;
            else          state_d   = CP;
          end
        end
        CP: if (stage_done) adv_layer = 1'b1;
        FC: begin
          if (stage_done) begin
            if (f_q != F_LAST) f_d     = f_q + 1'b1;
            else               state_d = FIN;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (adv_layer) begin
        if (l_q != L_LAST) begin
          l_d     = l_q + 1'b1;
          state_d = CW;
        end else begin
          f_d     = '0;
          state_d = FC;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    conv_load_d = '0;
    fc_start_d  = '0;
    busy_d      = (state_d != IDLE) && (state_d != FIN);
    done_d      = (state_d == FIN);
    layer_idx_d = (state_d == IDLE) ? '0 : l_d;
    err_d       = wd_expired && !abort;
    case (state_d)
      CW: conv_load_d[STG_W] = 1'b1;
      CI: conv_load_d[STG_I] = 1'b1;
      CS: conv_load_d[STG_S] = 1'b1;
      CR: conv_load_d[STG_R] = 1'b1;
      CP: conv_load_d[STG_P] = 1'b1;
      FC: begin
        for (int k = 0; k < NUM_FC; k++) begin
          if (f_d == FW'(k)) fc_start_d[k] = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  assign wd_clear = (state_q == IDLE) || (state_d != state_q) || (f_d != f_q) || abort;
  assign wd_run   = (state_q != IDLE) && (state_q != FIN) && !stage_done;

  cnn_seq_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign wd_expired         = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected output vectors are queued, a monitor checks each change.
module tb_cnn_layer_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_bit;
  logic       abort;
  logic [1:0] skip_pool;
  logic [4:0] conv_done;
  logic [1:0] fc_done;
  logic [4:0] conv_load;
  logic [2:0] layer_idx;
  logic [1:0] fc_start;
  logic       busy;
  logic       done_fwd;
  logic       err_timeout;

  localparam logic [4:0] LW = 5'b00001;
  localparam logic [4:0] LI = 5'b00010;
  localparam logic [4:0] LS = 5'b00100;
  localparam logic [4:0] LR = 5'b01000;
  localparam logic [4:0] LP = 5'b10000;
  localparam logic [4:0] L0 = 5'b00000;

  cnn_layer_sequencer #(
    .NUM_CONV   (2),
    .NUM_FC     (2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_bit  (start_bit),
    .abort      (abort),
    .skip_pool  (skip_pool),
    .conv_done  (conv_done),
    .fc_done    (fc_done),
    .conv_load  (conv_load),
    .layer_idx  (layer_idx),
    .fc_start   (fc_start),
    .busy       (busy),
    .done_fwd   (done_fwd),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // {conv_load, fc_start, layer_idx, busy, done_fwd, err_timeout}
  logic [12:0] obs;
  assign obs = {conv_load, fc_start, layer_idx, busy, done_fwd, err_timeout};

  function automatic logic [12:0] v(input logic [4:0] ld, input logic [1:0] fc,
                                    input logic [2:0] li, input logic b, input logic d,
                                    input logic e);
    return {ld, fc, li, b, d, e};
  endfunction

  int          vectors = 0;
  int          errors  = 0;
  int          rises   = 0;
  int          dones   = 0;
  logic        mon_en  = 1'b0;
  logic [12:0] prev    = '0;
  logic [12:0] mexp;
  logic [12:0] q[$];
  logic [12:0] t1[14];
  logic [12:0] t2[13];

  initial begin
    t1 = '{v(LW, 2'b00, 3'd0, 1, 0, 0), v(LI, 2'b00, 3'd0, 1, 0, 0), v(LS, 2'b00, 3'd0, 1, 0, 0),
           v(LR, 2'b00, 3'd0, 1, 0, 0), v(LP, 2'b00, 3'd0, 1, 0, 0), v(LW, 2'b00, 3'd1, 1, 0, 0),
           v(LI, 2'b00, 3'd1, 1, 0, 0), v(LS, 2'b00, 3'd1, 1, 0, 0), v(LR, 2'b00, 3'd1, 1, 0, 0),
           v(LP, 2'b00, 3'd1, 1, 0, 0), v(L0, 2'b01, 3'd1, 1, 0, 0), v(L0, 2'b10, 3'd1, 1, 0, 0),
           v(L0, 2'b00, 3'd1, 0, 1, 0), v(L0, 2'b00, 3'd0, 0, 0, 0)};
    t2 = '{v(LW, 2'b00, 3'd0, 1, 0, 0), v(LI, 2'b00, 3'd0, 1, 0, 0), v(LS, 2'b00, 3'd0, 1, 0, 0),
           v(LR, 2'b00, 3'd0, 1, 0, 0), v(LP, 2'b00, 3'd0, 1, 0, 0), v(LW, 2'b00, 3'd1, 1, 0, 0),
           v(LI, 2'b00, 3'd1, 1, 0, 0), v(LS, 2'b00, 3'd1, 1, 0, 0), v(LR, 2'b00, 3'd1, 1, 0, 0),
           v(L0, 2'b01, 3'd1, 1, 0, 0), v(L0, 2'b10, 3'd1, 1, 0, 0), v(L0, 2'b00, 3'd1, 0, 1, 0),
           v(L0, 2'b00, 3'd0, 0, 0, 0)};
  end

  // Monitor: every change on the outputs must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && (obs !== prev)) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change got %b need %b (no change expected)", obs, prev);
      end else begin
        mexp = q.pop_front();
        if (obs !== mexp) begin
          errors++;
          $display("FAIL out_vec got %b need %b", obs, mexp);
        end
      end
      if ((obs[12:6] != 7'd0) && (obs[12:6] != prev[12:6])) rises++;
      if (obs[1] && !prev[1]) dones++;
      prev = obs;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    vectors++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got %0h need %0h", name, got, need);
    end
  endtask

  task automatic push_t1(input int first, input int last);
    for (int i = first; i <= last; i++) q.push_back(t1[i]);
  endtask

  task automatic start_pass();
    start_bit = 1'b0;
    @(negedge clk);
    start_bit = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_load(output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    while ((conv_load == 5'd0) && (fc_start == 2'd0) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      ok = 1'b0;
      vectors++;
      errors++;
      $display("FAIL load_wait got no load need a load within 50 cycles");
    end
  endtask

  // Answer the active load with its done pulse roughly three cycles after it rose.
  task automatic serve(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_load(ok);
      if (!ok) return;
      repeat (2) @(negedge clk);
      conv_done = conv_load;
      fc_done   = fc_start;
      @(negedge clk);
      conv_done = '0;
      fc_done   = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish need finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  r0;
    int  d0;
    int  n;
    bit  ok;
    reset_n   = 1'b0;
    start_bit = 1'b0;
    abort     = 1'b0;
    skip_pool = 2'b00;
    conv_done = '0;
    fc_done   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(obs), 32'd0);
    reset_n = 1'b1;
    prev    = obs;
    mon_en  = 1'b1;

    // Full pass, no pooling skipped.
    r0 = rises; d0 = dones;
    push_t1(0, 13);
    start_pass();
    serve(12);
    repeat (4) @(negedge clk);
    chk("t1_load_count", 32'(rises - r0), 32'd12);
    chk("t1_done_pulses", 32'(dones - d0), 32'd1);

    // Layer 1 skips pooling; skip_pool changes after the start edge must be ignored.
    r0 = rises; d0 = dones;
    skip_pool = 2'b10;
    for (int i = 0; i < 13; i++) q.push_back(t2[i]);
    start_pass();
    skip_pool = 2'b01;
    serve(11);
    repeat (4) @(negedge clk);
    chk("t2_load_count", 32'(rises - r0), 32'd11);
    chk("t2_done_pulses", 32'(dones - d0), 32'd1);

    // Stray done bits while in CW.
    skip_pool = 2'b00;
    push_t1(0, 0);
    start_pass();
    wait_load(ok);
    conv_done = 5'b00100;
    @(negedge clk);
    conv_done = '0;
    fc_done   = 2'b11;
    @(negedge clk);
    fc_done   = '0;
    conv_done = 5'b11110;
    @(negedge clk);
    conv_done = '0;
    chk("t3_hold_w", 32'(conv_load), 32'(LW));
    push_t1(1, 7);
    serve(7);

    // Abort in CS at L=1 together with the S done; start_bit stays high.
    d0 = dones;
    q.push_back(t1[13]);
    repeat (2) @(negedge clk);
    abort     = 1'b1;
    conv_done = 5'b00100;
    @(negedge clk);
    abort     = 1'b0;
    conv_done = '0;
    repeat (10) @(negedge clk);
    chk("t4_idle_after_abort", 32'(obs), 32'd0);
    chk("t4_no_done_fwd", 32'(dones - d0), 32'd0);

    // Reset asserted during FC, then a fresh pass from layer 0.
    push_t1(0, 10);
    start_pass();
    serve(10);
    chk("t5_in_fc", 32'(fc_start), 32'd1);
    q.push_back(t1[13]);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_async_reset", 32'(obs), 32'd0);
    start_bit = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    r0 = rises; d0 = dones;
    push_t1(0, 13);
    start_pass();
    serve(12);
    repeat (4) @(negedge clk);
    chk("t5_restart_loads", 32'(rises - r0), 32'd12);
    chk("t5_restart_done", 32'(dones - d0), 32'd1);

    // Withhold the CI done.
    push_t1(0, 1);
    start_pass();
    serve(1);
`ifdef CNN_SEQ_TIMEOUT_EN
    q.push_back(v(L0, 2'b00, 3'd0, 0, 0, 1));
    q.push_back(t1[13]);
    n = 0;
    while (!err_timeout && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("t6_timeout_cycles", 32'(n), 32'd16);
    repeat (3) @(negedge clk);
    chk("t6_idle_after_timeout", 32'(obs), 32'd0);
`else
    n = 0;
    repeat (40) @(negedge clk);
    chk("t6_ci_holds", 32'(conv_load), 32'(LI));
    chk("t6_no_err_timeout", 32'(err_timeout), 32'(n));
    q.push_back(t1[13]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_after_abort", 32'(obs), 32'd0);
`endif

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
